// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master sequencer.
// One state per bus phase; the R/W bit is appended to the 7-bit device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_REG,
    ST_ACK_R,
    ST_WDATA,
    ST_ACK_D,
    ST_RSTART,
    ST_ADDR2,
    ST_ACK_A2,
    ST_RDATA,
    ST_MNACK,
    ST_STOP,
    ST_DONE
  } i2c_state_e;

  localparam logic       RW_WRITE           = 1'b0;
  localparam logic       RW_READ            = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h12;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timebase: counts CLK_DIV cycles per quarter and steps a 2-bit quarter index.
// hold freezes everything (clock stretching); clr parks the timer at quarter 0, count 0.
module i2c_quarter_timer #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  output logic       q_tick,
  output logic [1:0] quarter
);

  localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_quarter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_quarter <= 2'd0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_quarter <= 2'd0;
    end else if (!hold) begin
      if (r_cnt == LAST) begin
        r_cnt     <= '0;
        r_quarter <= r_quarter + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign q_tick  = !hold && (r_cnt == LAST);
  assign quarter = r_quarter;

endmodule

// File: rtl/i2c_master_seq.sv
// Byte-level I2C master: one register write or one register read (with repeated start)
// per accepted command, driving open-drain SCL/SDA enables.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | bus released, cmd_ready high
// START     | start condition
// ADDR      | device address + W, 8 bits
// ACK_A     | slave ACK for address
// REG       | register address, 8 bits
// ACK_R     | slave ACK for register address
// WDATA     | write data, 8 bits
// ACK_D     | slave ACK for write data
// RSTART    | repeated start (read only)
// ADDR2     | device address + R, 8 bits
// ACK_A2    | slave ACK for read address
// RDATA     | read data, SDA released, 8 bits
// MNACK     | master NACK, SDA released
// STOP      | stop condition
// DONE      | one-cycle response
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int STRETCH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  i2c_state_e r_state;
  i2c_state_e w_state_nxt;

  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic [2:0] r_bit;
  logic       r_nack;

  logic       w_q_tick;
  logic [1:0] w_quarter;
  logic       w_slot_end;
  logic       w_sample;
  logic       w_accept;
  logic       w_hold;
  logic       w_tmr_clr;
  logic       w_scl_oe;
  logic       w_sda_oe;
  logic       w_byte_state;
  logic       w_ack_state;

  assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
  assign w_slot_end   = w_q_tick && (w_quarter == 2'd3);
  assign w_sample     = w_q_tick && (w_quarter == 2'd2);
  assign w_tmr_clr    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_byte_state = r_state inside {ST_ADDR, ST_REG, ST_WDATA, ST_ADDR2, ST_RDATA};
  assign w_ack_state  = r_state inside {ST_ACK_A, ST_ACK_R, ST_ACK_D, ST_ACK_A2};

  // Stretching only applies while we have SCL released during an active frame.
  assign w_hold = (STRETCH != 0) && !w_tmr_clr && !w_scl_oe && !scl_in;

  i2c_quarter_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_tmr_clr),
    .hold    (w_hold),
    .q_tick  (w_q_tick),
    .quarter (w_quarter)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_state_nxt = ST_START;
      end
      ST_START, ST_RSTART: begin
        w_sda_oe = (w_quarter >= 2'd2);
        w_scl_oe = (w_quarter == 2'd3);
        if (w_slot_end) w_state_nxt = (r_state == ST_START) ? ST_ADDR : ST_ADDR2;
      end
      ST_ADDR, ST_REG, ST_WDATA, ST_ADDR2: begin
        w_scl_oe = (w_quarter < 2'd2);
        w_sda_oe = ~r_shift[7];
        if (w_slot_end && (r_bit == 3'd0)) begin
          case (r_state)
            ST_ADDR:  w_state_nxt = ST_ACK_A;
            ST_REG:   w_state_nxt = ST_ACK_R;
            ST_WDATA: w_state_nxt = ST_ACK_D;
            default:  w_state_nxt = ST_ACK_A2;
          endcase
        end
      end
      ST_ACK_A, ST_ACK_R, ST_ACK_D, ST_ACK_A2: begin
        w_scl_oe = (w_quarter < 2'd2);
        if (w_slot_end) begin
          if (r_nack) begin
            w_state_nxt = ST_STOP;
          end else begin
            case (r_state)
              ST_ACK_A:  w_state_nxt = ST_REG;
              ST_ACK_R:  w_state_nxt = (r_rw == RW_READ) ? ST_RSTART : ST_WDATA;
              ST_ACK_A2: w_state_nxt = ST_RDATA;
              default:   w_state_nxt = ST_STOP;
            endcase
          end
        end
      end
      ST_RDATA: begin
        w_scl_oe = (w_quarter < 2'd2);
        if (w_slot_end && (r_bit == 3'd0)) w_state_nxt = ST_MNACK;
      end
      ST_MNACK: begin
        w_scl_oe = (w_quarter < 2'd2);
        if (w_slot_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_scl_oe = (w_quarter == 2'd0);
        w_sda_oe = (w_quarter < 2'd2);
        if (w_slot_end) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rw    <= RW_WRITE;
      r_dev   <= DEFAULT_SLAVE_ADDR;
      r_reg   <= 8'h00;
      r_wdata <= 8'h00;
      r_shift <= 8'hFF;
      r_rx    <= 8'h00;
      r_rdata <= 8'h00;
      r_bit   <= 3'd7;
      r_nack  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw    <= cmd_rw;
        r_dev   <= cmd_dev_addr;
        r_reg   <= cmd_reg_addr;
        r_wdata <= cmd_wdata;
        r_nack  <= 1'b0;
        r_bit   <= 3'd7;
      end
      if (w_sample && w_ack_state && sda_in) r_nack <= 1'b1;
      if (w_sample && (r_state == ST_RDATA)) r_rx <= {r_rx[6:0], sda_in};
      // r_bit wraps 0 -> 7 at the end of each byte, ready for the next one.
      if (w_slot_end && w_byte_state) r_bit <= r_bit - 3'd1;
      if (w_slot_end) begin
        case (r_state)
          ST_START:  r_shift <= addr_byte(r_dev, RW_WRITE);
          ST_RSTART: r_shift <= addr_byte(r_dev, RW_READ);
          ST_ACK_A:  r_shift <= r_reg;
          ST_ACK_R:  r_shift <= r_wdata;
          ST_ADDR, ST_REG, ST_WDATA, ST_ADDR2: r_shift <= {r_shift[6:0], 1'b1};
          ST_STOP:   r_rdata <= ((r_rw == RW_READ) && !r_nack) ? r_rx : 8'h00;
          default:   r_shift <= r_shift;
        endcase
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_nack  = r_nack;
  assign rsp_rdata = r_rdata;
  assign scl_oe    = w_scl_oe;
  assign sda_oe    = w_sda_oe;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq: pull-ups plus a behavioural register slave at 7'h12.
// Slave START/STOP detection watches the master's SDA enable while SCL is high.
module tb_i2c_master_seq;

  localparam int         CLK_DIV   = 4;
  localparam int         LAT_LIMIT = 3000;
  localparam logic [6:0] SLV       = 7'h12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_addr = 7'h00;
  logic [7:0] cmd_reg_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  // slave model state
  logic       p_scl = 1'b1, p_moe = 1'b0;
  logic       s_active = 1'b0, s_ack = 1'b0, s_tx = 1'b0, s_rw = 1'b0, s_last_addr = 1'b0;
  logic       s_drive = 1'b0, s_scl_hold = 1'b0, s_mack = 1'b0, stretch_en = 1'b0;
  int         s_bitcnt = 0, s_byte_idx = 0, s_hcnt = 0;
  logic [7:0] s_shift = 8'h00, s_ptr = 8'h00, s_tx_sh = 8'h00;
  logic [7:0] s_mem [256];
  logic [8:0] s_log [$];
  logic       p_hold = 1'b0, p_sda_mon = 1'b1;
  int         sda_chg = 0;

  i2c_master_seq #(.CLK_DIV(CLK_DIV), .STRETCH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_nack     (rsp_nack),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .scl_in       (scl_in),
    .sda_in       (sda_in)
  );

  assign scl_in = ~(scl_oe | s_scl_hold);
  assign sda_in = ~(sda_oe | s_drive);

  always #5 clk = ~clk;

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  always @(posedge clk) begin
    if (p_hold && s_scl_hold && (sda_in !== p_sda_mon)) sda_chg <= sda_chg + 1;
    p_hold    <= s_scl_hold;
    p_sda_mon <= sda_in;
  end

  always @(posedge clk) begin
    p_scl <= scl_in;
    p_moe <= sda_oe;
    if (p_scl && scl_in && !p_moe && sda_oe) begin
      s_log.push_back(9'h100);
      s_active <= 1'b1; s_ack <= 1'b0; s_tx <= 1'b0; s_drive <= 1'b0;
      s_bitcnt <= 0; s_byte_idx <= 0;
    end else if (p_scl && scl_in && p_moe && !sda_oe) begin
      s_active <= 1'b0; s_ack <= 1'b0; s_tx <= 1'b0; s_drive <= 1'b0;
    end else if (s_active && !p_scl && scl_in) begin
      if (s_ack) begin
        if (s_tx) s_mack <= sda_in;
      end else if (s_bitcnt < 8) begin
        if (!s_tx) s_shift <= {s_shift[6:0], sda_in};
        s_bitcnt <= s_bitcnt + 1;
      end
    end else if (s_active && p_scl && !scl_in) begin
      if (s_ack) begin
        s_ack <= 1'b0;
        s_bitcnt <= 0;
        if (s_tx) begin
          s_tx <= 1'b0; s_drive <= 1'b0; s_active <= 1'b0;
        end else if (s_last_addr && s_rw) begin
          s_tx <= 1'b1;
          s_drive <= ~s_mem[s_ptr][7];
          s_tx_sh <= {s_mem[s_ptr][6:0], 1'b0};
        end else begin
          s_drive <= 1'b0;
        end
      end else if (s_bitcnt == 8) begin
        if (s_tx) begin
          s_ack <= 1'b1; s_drive <= 1'b0;
        end else begin
          s_log.push_back({1'b0, s_shift});
          s_byte_idx <= s_byte_idx + 1;
          if (s_byte_idx == 0) begin
            if (s_shift[7:1] == SLV) begin
              s_ack <= 1'b1; s_drive <= 1'b1; s_rw <= s_shift[0]; s_last_addr <= 1'b1;
            end else begin
              s_active <= 1'b0;
            end
          end else begin
            s_ack <= 1'b1; s_drive <= 1'b1; s_last_addr <= 1'b0;
            if (s_byte_idx == 1) begin
              s_ptr <= s_shift;
              if (stretch_en) begin s_scl_hold <= 1'b1; s_hcnt <= 0; end
            end else begin
              s_mem[s_ptr] <= s_shift;
              s_ptr <= s_ptr + 8'd1;
            end
          end
        end
      end else if (s_tx) begin
        s_drive <= ~s_tx_sh[7];
        s_tx_sh <= {s_tx_sh[6:0], 1'b0};
      end
    end
    // Hold SCL low for 37 cycles counted from when the master releases it.
    if (s_scl_hold && !scl_oe) begin
      s_hcnt <= s_hcnt + 1;
      if (s_hcnt == 36) s_scl_hold <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] log_pack();
    logic [63:0] p;
    p = '0;
    foreach (s_log[i]) p = {p[54:0], s_log[i]};
    return p;
  endfunction

  task automatic start_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    @(negedge clk);
    s_log.delete();
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(inout int lat);
    while (rsp_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, output int lat);
    start_cmd(rw, dev, rg, wd);
    lat = 1;
    wait_rsp(lat);
  endtask

  initial begin
    int lat;
    int cnt0;
    foreach (s_mem[i]) s_mem[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_nack", rsp_nack, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: register write
    run_cmd(1'b0, 7'h12, 8'h05, 8'hA5, lat);
    check("wr_latency", lat, 465);
    check("wr_nack", rsp_nack, 1'b0);
    check("wr_rdata", rsp_rdata, 8'h00);
    check("wr_busy_at_rsp", busy, 1'b1);
    check("wr_bus_bytes", log_pack(), {9'h100, 9'h024, 9'h005, 9'h0A5});
    check("wr_slave_mem", s_mem[8'h05], 8'hA5);
    repeat (5) @(negedge clk);

    // 2: register read back
    s_mack = 1'b0;
    run_cmd(1'b1, 7'h12, 8'h05, 8'h00, lat);
    check("rd_latency", lat, 625);
    check("rd_rdata", rsp_rdata, 8'hA5);
    check("rd_nack", rsp_nack, 1'b0);
    check("rd_bus_bytes", log_pack(), {9'h100, 9'h024, 9'h005, 9'h100, 9'h025});
    check("rd_master_nack", s_mack, 1'b1);
    repeat (5) @(negedge clk);

    // 5: reset pulse in the middle of the REG byte
    start_cmd(1'b0, 7'h12, 8'h06, 8'h77);
    repeat (199) @(negedge clk);
    cnt0 = rsp_cnt;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_scl_oe", scl_oe, 1'b0);
    check("mid_rst_sda_oe", sda_oe, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    check("mid_rst_no_rsp", rsp_cnt - cnt0, 0);
    check("mid_rst_mem_untouched", s_mem[8'h06], 8'h00);
    run_cmd(1'b0, 7'h12, 8'h0A, 8'hC3, lat);
    check("post_rst_latency", lat, 465);
    check("post_rst_nack", rsp_nack, 1'b0);
    check("post_rst_bus_bytes", log_pack(), {9'h100, 9'h024, 9'h00A, 9'h0C3});
    repeat (5) @(negedge clk);

    // 3: write to absent device
    run_cmd(1'b0, 7'h13, 8'h05, 8'h11, lat);
    check("nack_latency", lat, 177);
    check("nack_flag", rsp_nack, 1'b1);
    check("nack_rdata", rsp_rdata, 8'h00);
    check("nack_bus_bytes", log_pack(), {9'h100, 9'h026});
    repeat (5) @(negedge clk);

    // 4: clock stretching during ACK_R
    stretch_en = 1'b1;
    sda_chg = 0;
    run_cmd(1'b0, 7'h12, 8'h09, 8'h5A, lat);
    stretch_en = 1'b0;
    check("stretch_latency", lat, 465 + 37);
    check("stretch_hold_cycles", s_hcnt, 37);
    check("stretch_sda_stable", sda_chg, 0);
    check("stretch_nack", rsp_nack, 1'b0);
    check("stretch_slave_mem", s_mem[8'h09], 8'h5A);
    repeat (5) @(negedge clk);

    // 6: cmd_valid held with changing fields while busy
    cnt0 = rsp_cnt;
    @(negedge clk);
    s_log.delete();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h12; cmd_reg_addr = 8'h07; cmd_wdata = 8'h3C;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
      if (rsp_valid !== 1'b1) begin
        cmd_rw       = 1'($urandom_range(0, 1));
        cmd_dev_addr = 7'($urandom_range(0, 127));
        cmd_reg_addr = 8'($urandom_range(0, 255));
        cmd_wdata    = 8'($urandom_range(0, 255));
      end
    end
    cmd_valid = 1'b0;
    check("hold_valid_latency", lat, 465);
    repeat (20) @(negedge clk);
    check("hold_valid_one_rsp", rsp_cnt - cnt0, 1);
    check("hold_valid_idle", busy, 1'b0);
    check("hold_valid_mem", s_mem[8'h07], 8'h3C);
    check("hold_valid_bus_bytes", log_pack(), {9'h100, 9'h024, 9'h007, 9'h03C});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
